// File: rtl/axi_pkg.sv
// Purpose: shared AXI4 constants (burst types, response codes) and the write-master FSM state type.
// Latency: none, declarations only.
// Backpressure: not applicable.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Normal non-cacheable bufferable memory.
  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wm_state_t;

endpackage

// File: rtl/axi_burst_len_calc.sv
// Purpose: beats for the next burst = min(remaining, MAX_BURST_LEN[, beats left in the 4 KiB page]).
// Latency: purely combinational.
// Backpressure: none.
// Ports: addr (aligned byte address of the burst), remaining (beats still to send), beats (1..256, 9 bits).
// Option: AXI_WRITE_MASTER_4K_SPLIT_EN defined -> bursts never cross a 4 KiB boundary.
module axi_burst_len_calc #(
  parameter int ADDR_WIDTH    = 16,
  parameter int LEN_WIDTH     = 16,
  parameter int STRB_WIDTH    = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  remaining,
  output logic [8:0]            beats
);

  localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
  // Narrow address spaces are zero-extended so the page offset is always 12 bits.
  localparam int AW_EXT     = (ADDR_WIDTH > 12) ? ADDR_WIDTH : 12;

  logic [AW_EXT-1:0] addr_ext;
  logic [31:0]       page_beats;
  logic [31:0]       lim;
  logic              unused_bits;

  assign addr_ext = AW_EXT'(addr);

  // Address is beat-aligned, so the division by STRB_WIDTH is exact.
  assign page_beats = (32'd4096 - 32'(addr_ext[11:0])) >> BYTE_SHIFT;

  always_comb begin
    lim = 32'(remaining);
    if (lim > 32'(MAX_BURST_LEN)) lim = 32'(MAX_BURST_LEN);
`ifdef AXI_WRITE_MASTER_4K_SPLIT_EN
    if (lim > page_beats) lim = page_beats;
`endif
  end

  assign beats = lim[8:0];

  assign unused_bits = ^{addr_ext, lim[31:9], page_beats};

endmodule

// File: rtl/axi_stream_write_master.sv
// Purpose: command-driven AXI4 write master; splits a stream transfer into INCR bursts, one outstanding.
// Latency: AW one cycle after command/B handshake; W pass-through (0 cycles); done one cycle after final B.
// Backpressure: s_axis_tready follows m_axi_wready in DATA only; cmd_ready only while idle.
// Ports: cmd_* command in; s_axis_* stream in; m_axi_aw*/w*/b* AXI4 write channels; done/done_error/busy status.
// Option: AXI_WRITE_MASTER_4K_SPLIT_EN (see axi_burst_len_calc) keeps bursts inside 4 KiB pages.
module axi_stream_write_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  done,
  output logic                  done_error,
  output logic                  busy,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);
  import axi_pkg::*;

  localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  wm_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [8:0]            beats_q;
  logic [8:0]            beat_cnt_q;
  logic [7:0]            awlen_q;
  logic                  awvalid_q;
  logic                  err_q;
  logic                  done_q;
  logic                  done_err_q;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  next_rem;
  logic [8:0]            calc_beats;
  logic                  w_fire;
  logic                  last_beat;
  logic                  b_err;
  logic                  unused_bid;

  // The burst calculator always looks at the address/remaining that will be current
  // after this cycle's handshake, so awlen can be registered together with awvalid.
  always_comb begin
    if (state == IDLE) begin
      next_addr = cmd_addr & ALIGN_MASK;
      next_rem  = cmd_len;
    end else begin
      next_addr = addr_q + (ADDR_WIDTH'(beats_q) << BYTE_SHIFT);
      next_rem  = remaining_q - LEN_WIDTH'(beats_q);
    end
  end

  axi_burst_len_calc #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .STRB_WIDTH    (STRB_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len_calc (
    .addr      (next_addr),
    .remaining (next_rem),
    .beats     (calc_beats)
  );

  assign w_fire    = (state == DATA) && s_axis_tvalid && m_axi_wready;
  assign last_beat = (beat_cnt_q == beats_q - 9'd1);
  assign b_err     = (m_axi_bresp != RESP_OKAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    s_axis_tready = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && (cmd_len != '0)) state_nxt = ADDR;
      end
      ADDR: begin
        if (m_axi_awready) state_nxt = DATA;
      end
      DATA: begin
        s_axis_tready = m_axi_wready;
        m_axi_wvalid  = s_axis_tvalid;
        m_axi_wlast   = last_beat;
        if (w_fire && last_beat) state_nxt = RESP;
      end
      RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = (next_rem == '0) ? IDLE : ADDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q      <= next_addr;
            remaining_q <= next_rem;
            err_q       <= 1'b0;
            if (next_rem == '0) begin
              done_q <= 1'b1;
            end else begin
              awvalid_q <= 1'b1;
              awlen_q   <= 8'(calc_beats - 9'd1);
              beats_q   <= calc_beats;
            end
          end
        end
        ADDR: begin
          if (m_axi_awready) begin
            awvalid_q  <= 1'b0;
            beat_cnt_q <= '0;
          end
        end
        DATA: begin
          if (w_fire) beat_cnt_q <= beat_cnt_q + 9'd1;
        end
        RESP: begin
          if (m_axi_bvalid) begin
            addr_q      <= next_addr;
            remaining_q <= next_rem;
            // Error responses are sticky for the command but never abort it.
            err_q       <= err_q | b_err;
            if (next_rem == '0) begin
              done_q     <= 1'b1;
              done_err_q <= err_q | b_err;
            end else begin
              awvalid_q <= 1'b1;
              awlen_q   <= 8'(calc_beats - 9'd1);
              beats_q   <= calc_beats;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(BYTE_SHIFT);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AWCACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign done          = done_q;
  assign done_error    = done_err_q;

  // Only one burst is ever outstanding, so the response ID carries no information.
  assign unused_bid = ^m_axi_bid;

endmodule

// File: tb/tb_axi_stream_write_master.sv
module tb_axi_stream_write_master;

  localparam int MAXB = 16;
  localparam int SW   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        done, done_error, busy;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [7:0]  m_axi_bid = 8'h5A;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  axi_stream_write_master dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .done(done), .done_error(done_error), .busy(busy),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected burst plan for the current command.
  int m_addr[$];
  int m_beats[$];
  // Bursts actually issued by the DUT.
  int o_addr[$];
  int o_len[$];
  // Slave memory, word per byte address.
  logic [31:0] mem [int];
  logic last_done_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plan: contiguous INCR beats from the aligned start, chopped into bursts.
  function automatic void plan(input int a, input int len);
    int cur, rem, b, room;
    m_addr.delete();
    m_beats.delete();
    cur = a & 'hFFFC;
    rem = len;
    while (rem > 0) begin
      b = (rem < MAXB) ? rem : MAXB;
`ifdef AXI_WRITE_MASTER_4K_SPLIT_EN
      room = (4096 - (cur % 4096)) / SW;
      if (b > room) b = room;
`else
      room = b;
`endif
      m_addr.push_back(cur);
      m_beats.push_back(b);
      cur = (cur + b * SW) % 65536;
      rem -= b;
    end
  endfunction

  task automatic run_cmd(input int a, input int len, input int base, input int gap,
                         input int stall, input int err_burst);
    int  di, wb, wbeat, nb, bdone, accept_cyc, last_evt, cyc;
    bit  pend, bpend, finished, exp_err, t_taken, b_taken;
    plan(a, len);
    nb = m_addr.size();
    o_addr.delete();
    o_len.delete();
    mem.delete();
    exp_err = (err_burst >= 1) && (err_burst <= nb);
    di = 0; wb = 0; wbeat = 0; bdone = 0; cyc = 0; accept_cyc = -1; last_evt = -1;
    pend = 1; bpend = 0; finished = 0; t_taken = 0; b_taken = 0;
    while (!finished) begin
      @(negedge clk);
      cmd_valid = pend;
      cmd_addr  = 16'(a);
      cmd_len   = 16'(len);
      if (t_taken) begin s_axis_tvalid = 1'b0; t_taken = 0; end
      if (!s_axis_tvalid) begin
        s_axis_tvalid = (di < len) && ($urandom_range(99) >= gap);
        s_axis_tdata  = 32'(base + di + 1);
      end
      m_axi_awready = ($urandom_range(99) >= stall);
      m_axi_wready  = ($urandom_range(99) >= stall);
      if (b_taken) begin m_axi_bvalid = 1'b0; b_taken = 0; end
      if (bpend && !m_axi_bvalid) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (bdone + 1 == err_burst) ? 2'b10 : 2'b00;
        bpend = 0;
      end
      #1;
      if (cmd_valid && cmd_ready) begin
        pend = 0;
        accept_cyc = cyc;
        if (len == 0) last_evt = cyc;
      end else if (accept_cyc >= 0 && len > 0 && !done) begin
        chk("busy", busy, 1);
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (o_addr.size() < nb) begin
          chk("awaddr", m_axi_awaddr, m_addr[o_addr.size()]);
          chk("awlen", m_axi_awlen, m_beats[o_addr.size()] - 1);
        end else begin
          chk("extra_aw", o_addr.size(), nb - 1);
        end
        chk("aw_fixed", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
            {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
        o_addr.push_back(int'(m_axi_awaddr));
        o_len.push_back(int'(m_axi_awlen));
      end
      if (m_axi_wvalid) chk("tready_tie", s_axis_tready, m_axi_wready);
      else if (s_axis_tvalid) chk("tready_idle", s_axis_tready, 0);
      if (m_axi_wvalid && m_axi_wready) begin
        chk("wdata", m_axi_wdata, 32'(base + di + 1));
        chk("wstrb", m_axi_wstrb, 4'hF);
        if (wb >= nb) begin
          chk("extra_w", wb, nb - 1);
        end else if (wb >= o_addr.size()) begin
          chk("w_before_aw", o_addr.size(), wb + 1);
        end else begin
          chk("wlast", m_axi_wlast, (wbeat == m_beats[wb] - 1));
          mem[(o_addr[wb] + wbeat * SW) % 65536] = m_axi_wdata;
          wbeat++;
          if (wbeat == m_beats[wb]) begin
            wbeat = 0;
            wb++;
            bpend = 1;
          end
        end
        di++;
        t_taken = 1;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        bdone++;
        b_taken = 1;
        if (bdone == nb) last_evt = cyc;
      end
      if (done) begin
        chk("done_when", cyc, last_evt + 1);
        chk("done_error", done_error, exp_err);
        chk("bursts_done", bdone, nb);
        chk("beats_sent", di, len);
        last_done_err = done_error;
        finished = 1;
      end
      cyc++;
      if (cyc > 3000) begin
        chk("timeout", cyc, 0);
        finished = 1;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    s_axis_tvalid = 1'b0;
    if (b_taken) m_axi_bvalid = 1'b0;
    #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < len; i++)
      chk("readback", mem[((a & 'hFFFC) + i * SW) % 65536], 32'(base + i + 1));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done, done_error}, 2'b00);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_wlast", m_axi_wlast, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_aw_payload", {m_axi_awaddr, m_axi_awlen}, 24'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single 4-beat burst, data 1..4
    run_cmd('h0100, 4, 0, 0, 0, 0);
    chk("t1_nbursts", o_addr.size(), 1);
    if (o_addr.size() == 1) begin
      chk("t1_awaddr", o_addr[0], 'h0100);
      chk("t1_awlen", o_len[0], 3);
    end
    chk("t1_mem_10c", mem['h010C], 4);

    // 40 beats -> 16/16/8
    run_cmd('h0000, 40, 100, 0, 0, 0);
    chk("t2_nbursts", o_addr.size(), 3);
    if (o_addr.size() == 3) begin
      chk("t2_addrs", {16'(o_addr[0]), 16'(o_addr[1]), 16'(o_addr[2])}, 48'h0000_0040_0080);
      chk("t2_lens", {8'(o_len[0]), 8'(o_len[1]), 8'(o_len[2])}, 24'h0F_0F_07);
    end

    // 4 KiB boundary
    run_cmd('h0FF0, 16, 200, 0, 0, 0);
`ifdef AXI_WRITE_MASTER_4K_SPLIT_EN
    chk("t3_nbursts", o_addr.size(), 2);
    if (o_addr.size() == 2) begin
      chk("t3_addrs", {16'(o_addr[0]), 16'(o_addr[1])}, 32'h0FF0_1000);
      chk("t3_lens", {8'(o_len[0]), 8'(o_len[1])}, 16'h03_0B);
    end
`else
    chk("t3_nbursts", o_addr.size(), 1);
    if (o_addr.size() == 1) begin
      chk("t3_addr", o_addr[0], 'h0FF0);
      chk("t3_len", o_len[0], 15);
    end
`endif

    // Zero-length command: no AXI traffic
    run_cmd('h0203, 0, 300, 0, 0, 0);
    chk("t4_no_aw", o_addr.size(), 0);
    chk("t4_err", last_done_err, 0);

    // Stream gaps and slave stalls
    run_cmd('h2000, 20, 400, 40, 40, 0);

    // SLVERR on burst 2 of 3
    run_cmd('h3000, 40, 500, 20, 20, 2);
    chk("t6_nbursts", o_addr.size(), 3);
    chk("t6_err", last_done_err, 1);

    // Clean command after an error
    run_cmd('h3100, 8, 600, 0, 0, 0);
    chk("t7_err", last_done_err, 0);

    // Unaligned start near top of address space, wraps to 0
    run_cmd('hFFF9, 4, 700, 0, 30, 0);
    if (o_addr.size() > 0) chk("t8_first_addr", o_addr[0], 'hFFF8);

    // Reset while a burst address is pending
    @(negedge clk);
    m_axi_awready = 1'b0;
    cmd_addr = 16'h0400;
    cmd_len = 16'd8;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("mid_awvalid_pre", m_axi_awvalid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_awvalid", m_axi_awvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run_cmd('h0500, 3, 800, 0, 0, 0);
    chk("t9_nbursts", o_addr.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
